// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int unsigned FQ_AW = 32;
    localparam int unsigned FQ_DW = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [FQ_AW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch: the address and the instruction word read from it.
    typedef struct packed {
        logic [FQ_AW-1:0] pc;
        logic [FQ_DW-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory read port and decode-side valid/ready handshake of the fetch queue.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int unsigned AW = FQ_AW,
    parameter int unsigned DW = FQ_DW
);
    logic          IM_read;
    logic [AW-1:0] IM_addr;
    logic [DW-1:0] IM_out;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_inst;
    logic          if_ready;

    modport master (
        output IM_read, IM_addr, if_valid, if_pc, if_inst,
        input  IM_out, if_ready
    );

    modport slave (
        input  IM_read, IM_addr, if_valid, if_pc, if_inst,
        output IM_out, if_ready
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// Register ring holding queued {pc, inst} entries; one write port, asynchronous read.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);
    fq_entry_t mem_q [DEPTH];

    // Data array carries no reset; validity is tracked by the queue control.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch, credit-limited issue, flush/redirect.
// Optional same-cycle bypass of returning read data when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   AW       = FQ_AW,
    parameter int unsigned   DW       = FQ_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [AW-1:0]   new_addr,
    fetch_queue_if.master   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned KW = CW + 1;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic      head_valid_c;
    logic      bypass_c;
    logic      deq_c;
    logic      deq_store_c;
    logic      enq_c;
    logic      issue_c;
    logic [KW-1:0] credit_c;
    fq_entry_t head_c;
    fq_entry_t wr_entry_c;

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (enq_c),
        .waddr (wr_ptr_q),
        .wdata (wr_entry_c),
        .raddr (rd_ptr_q),
        .rdata (head_c)
    );

    assign head_valid_c = (count_q != '0);
    assign wr_entry_c   = '{pc: FQ_AW'(inflight_pc_q), inst: FQ_DW'(bus.IM_out)};

    // Decode-side view: storage head, or the returning read when bypass is built in.
    always_comb begin
        bypass_c = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_c = !head_valid_c && inflight_q;
`endif
        bus.if_valid = head_valid_c || bypass_c;
        bus.if_pc    = '0;
        bus.if_inst  = '0;
        if (bypass_c) begin
            bus.if_pc   = inflight_pc_q;
            bus.if_inst = bus.IM_out;
        end else if (head_valid_c) begin
            bus.if_pc   = AW'(head_c.pc);
            bus.if_inst = DW'(head_c.inst);
        end
    end

    // A read may issue only if every outstanding fetch still has a slot after this dequeue.
    always_comb begin
        deq_c       = bus.if_valid && bus.if_ready;
        deq_store_c = deq_c && head_valid_c;
        enq_c       = inflight_q && !flush && !(bypass_c && deq_c);
        credit_c    = KW'(count_q) + KW'(inflight_q) - KW'(deq_c);
        issue_c     = !rst && !flush && (credit_c < KW'(DEPTH));
        bus.IM_read = issue_c;
        bus.IM_addr = fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (flush) begin
            fetch_pc_d = new_addr;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_store_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d    = count_q + CW'(enq_c) - CW'(deq_store_c);
            inflight_d = issue_c;
            if (issue_c) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + AW'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a stream-level model of fetch, credit and delivery.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] new_addr = '0;

    fetch_queue_if #(.AW(32), .DW(32)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .AW       (32),
        .DW       (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .new_addr (new_addr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory with one-cycle registered read.
    always @(posedge clk) bus.IM_out <= bus.IM_addr ^ KEY;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: counts since the last flush/reset.
    int          issued;
    int          accepted;
    bit          last_issue;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        issued     = 0;
        accepted   = 0;
        last_issue = 1'b0;
        exp_addr   = pc;
        exp_pc     = pc;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1'b1;
            flush = 1'b0;
            bus.if_ready = 1'b0;
            #1;
            if (i > 0) begin
                check_eq("rst_IM_read", 32'(bus.IM_read), 32'd0);
                check_eq("rst_IM_addr", bus.IM_addr, RST_PC);
                check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
                check_eq("rst_if_pc", bus.if_pc, 32'd0);
                check_eq("rst_if_inst", bus.if_inst, 32'd0);
            end
        end
        model_restart(RST_PC);
    endtask

    // One cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic rdy, input logic fl, input logic [31:0] na);
        int  avail;
        int  outstanding;
        bit  exp_valid;
        bit  deq;
        bit  exp_read;
        @(negedge clk);
        rst = 1'b0;
        bus.if_ready = rdy;
        flush = fl;
        new_addr = na;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        avail = issued - accepted;
`else
        avail = issued - int'(last_issue) - accepted;
`endif
        exp_valid = (avail > 0);
        check_eq("if_valid", 32'(bus.if_valid), 32'(exp_valid));
        deq = exp_valid && rdy;
        if (deq && !fl) begin
            check_eq("if_pc", bus.if_pc, exp_pc);
            check_eq("if_inst", bus.if_inst, exp_pc ^ KEY);
        end
        outstanding = issued - accepted - int'(deq);
        exp_read = !fl && (outstanding < int'(DEPTH));
        check_eq("IM_read", 32'(bus.IM_read), 32'(exp_read));
        if (exp_read) check_eq("IM_addr", bus.IM_addr, exp_addr);
        if (fl) begin
            model_restart(na);
        end else begin
            if (deq) begin
                accepted++;
                exp_pc = exp_pc + 32'd4;
            end
            if (exp_read) begin
                issued++;
                exp_addr = exp_addr + 32'd4;
            end
            last_issue = exp_read;
        end
    endtask

    initial begin
        logic [31:0] r;
        bus.if_ready = 1'b0;
        do_reset(2);

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);

        // Decode stall: queue fills, fetch stops, then drains in order.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Flush while nearly full with a read outstanding.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // Back-to-back flushes: last target wins.
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // Address wrap with toggling ready.
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) step(1'(i % 2 == 0), 1'b0, '0);

        // Random ready and occasional redirect.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            r = r & 32'hFFFF_FFFC;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), r);
        end

        // Mid-stream reset with entries queued, then restart from the reset pc.
        step(1'b0, 1'b1, 32'h0000_0400);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        do_reset(2);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
